// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit serial link: state encoding, line levels
// and a counter-width helper used by both the transmit and receive ends.
package serial_link_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] link_state_t;

  localparam link_state_t IDLE   = 3'd0;
  localparam link_state_t START  = 3'd1;
  localparam link_state_t DATA   = 3'd2;
  localparam link_state_t PARITY = 3'd3;
  localparam link_state_t STOP   = 3'd4;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // A counter over n values never needs fewer than one bit, even for n = 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_shifter_if.sv
// Word-side handshake and serial line of the transmitter, grouped as one bundle.
interface serial_tx_shifter_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data;
  logic                  load;
  logic                  ready;
  logic                  serialOut;
  logic                  busy;
  logic                  done;

  modport master (
    output data, load,
    input  ready, serialOut, busy, done
  );

  modport slave (
    input  data, load,
    output ready, serialOut, busy, done
  );

endinterface

// File: rtl/serial_tx_shifter_bit_period_counter.sv
// Bit period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count with a tick. Shared with the receive end of the link.
module bit_period_counter
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-in serial-out transmitter: start bit, data bits, optional even parity
// (macro SERIAL_TX_PARITY_EN), stop bit, each held CLKS_PER_BIT clocks.
module serial_tx_shifter
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_tx_shifter_if.slave   link
);

  localparam int            BW       = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  link_state_t           state;
  link_state_t           state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic                  done_q;
  logic                  tick;
  logic                  accept;
  logic                  tx_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic                  par_q;
`endif

  assign accept = (state == IDLE) && link.load;
  assign tx_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_WIDTH-1];

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_period (
    .clock  (clock),
    .reset  (reset),
    .enable (state != IDLE),
    .clear  (state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (link.load) state_nxt = START;
      START:  if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word capture on accept; shift one bit per terminal count while in DATA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= (state == STOP) && tick;
      if (accept) begin
        shreg   <= link.data;
        bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
        par_q   <= ^link.data;
`endif
      end else if ((state == DATA) && tick) begin
        bit_cnt <= bit_cnt + BW'(1);
        if (LSB_FIRST != 0) begin
          shreg <= shreg >> 1;
        end else begin
          shreg <= shreg << 1;
        end
      end
    end
  end

  always_comb begin
    link.serialOut = IDLE_LEVEL;
    link.busy      = (state != IDLE);
    link.ready     = (state == IDLE);
    link.done      = done_q;
    case (state)
      START:  link.serialOut = START_LEVEL;
      DATA:   link.serialOut = tx_bit;
`ifdef SERIAL_TX_PARITY_EN
      PARITY: link.serialOut = par_q;
`endif
      STOP:   link.serialOut = STOP_LEVEL;
      default: link.serialOut = IDLE_LEVEL;
    endcase
  end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Parallel-in, serial-out transmitter: the transmit end of the team's single-bit serial link, whose receive end is a D-flip-flop shift chain.
- Accepts a parallel word via a load/ready handshake and frames it on one line: start bit, data bits, optional parity, stop bit.
- Each bit is held for a programmable number of clock cycles.
- Sits between any word-producing block and an off-block serial pin or receiver.

Parameters:
- DATA_WIDTH, 8, bits per word (>=1)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
- LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit DATA_WIDTH-1 sent first

Ports:
- clock  input  1  single system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- data  input  DATA_WIDTH  word to transmit; sampled only on an accepted load
- load  input  1  request to transmit data
- ready  output  1  high when a load will be accepted this cycle
- serialOut  output  1  serial line; idles high
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (reset low, asynchronous, effective immediately):
  - state=IDLE, serialOut=1, ready=1, busy=0, done=0.
  - Shift register, bit counter and period counter cleared.
  - Reset mid-frame aborts the frame; no done pulse.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - ready=1, busy=0, serialOut=1.
  - load=1 on a rising edge captures data into the shift register and moves to START.
- Latency: serialOut goes low in the cycle immediately after the accepting edge.
- Period counter:
  - Counts 0..CLKS_PER_BIT-1 in each non-IDLE state.
  - On terminal count, advance bit/state and reset to 0.
  - CLKS_PER_BIT=1 gives one bit per cycle.
- START: serialOut=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - serialOut = shift register bit 0 (LSB_FIRST=1) or bit DATA_WIDTH-1 (LSB_FIRST=0).
  - Shift on each terminal count.
  - Bit counter width $clog2(DATA_WIDTH+1). After DATA_WIDTH bits, go to PARITY if enabled, else STOP.
- STOP:
  - serialOut=1 for CLKS_PER_BIT cycles, then IDLE.
  - done=1 for exactly the first IDLE cycle.
- Handshake:
  - ready=~busy, combinationally from state.
  - load while busy is ignored; it is not queued and data is not sampled.
  - load held high continuously produces back-to-back frames with exactly one idle-high cycle between them; the done cycle is also an accept cycle.
- data may change freely after the accepting edge without affecting the frame.
- Frame length: (2 + DATA_WIDTH [+1 parity]) * CLKS_PER_BIT cycles from the accepting edge to the last stop cycle.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP.
  - serialOut = XOR of the captured word (even parity) for CLKS_PER_BIT cycles.
  - Parity is computed at capture and stored in one flip-flop.
- Undefined: no PARITY state, no parity flip-flop; DATA goes directly to STOP.

Decomposition:
- Shared package serial_link_pkg:
  - State encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit state width.
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1, for reuse by the receiver.
- Sub-module bit_period_counter:
  - Parameter CLKS_PER_BIT; ports clock, reset, enable, clear, tick.
  - Generates terminal-count ticks; shared with the receiver.

Test Plan:
1. Reset check: hold reset low for 3 cycles with load=1 → serialOut=1, ready=1, busy=0, done=0 throughout; no frame starts.
2. Single frame (DATA_WIDTH=8, CLKS_PER_BIT=4, LSB_FIRST=1), 0xA5 loaded at edge 0:
   - serialOut=0 in cycles 1–4.
   - Data bits 1,0,1,0,0,1,0,1 in 4-cycle blocks over cycles 5–36.
   - serialOut=1 in cycles 37–40.
   - done=1 and ready=1 in cycle 41 only.
3. Busy rejection: load 0x3C at edge 0, then load 0xFF at cycle 10 → transmitted bits match 0x3C; second load ignored; exactly one done pulse.
4. Back-to-back: load held high with 0x01 then 0x80 → second start bit begins in cycle 42; one idle-high cycle (41) between frames; two done pulses 41 cycles apart.
5. Reset mid-frame: assert reset at cycle 15 of a 0x00 frame → serialOut=1 immediately (asynchronous), no done pulse; a new load after release transmits normally.
6. With SERIAL_TX_PARITY_EN:
   - 0xA5 → parity bit 0 in cycles 37–40, stop in 41–44, done in 45.
   - 0x07 → parity bit 1.
